// File: rtl/gate_unit_arbiter_pkg.sv
// Shared types for the gate-unit arbiter: opcodes and FSM states.
// Imported by the arbiter top and its gate ALU.
package gate_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_NOT = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/gate_alu.sv
// Combinational bitwise gate unit built from gate primitives.
// A 4:1 mux on the opcode picks NOT/AND/OR/XOR.
module gate_alu
  import gate_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH-1:0] n_w;
  logic [WIDTH-1:0] and_w;
  logic [WIDTH-1:0] or_w;
  logic [WIDTH-1:0] xor_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    not u_not (n_w[i], a_i[i]);
    and u_and (and_w[i], a_i[i], b_i[i]);
    or  u_or  (or_w[i], a_i[i], b_i[i]);
    xor u_xor (xor_w[i], a_i[i], b_i[i]);
  end

  always_comb begin
    y_o = '0;
    unique case (op_e'(op_i))
      OP_NOT: y_o = n_w;
      OP_AND: y_o = and_w;
      OP_OR:  y_o = or_w;
      OP_XOR: y_o = xor_w;
    endcase
  end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one gate ALU between N_REQ requesters.
// One operation in flight: IDLE grant -> EXEC compute -> RESP hold.
module gate_unit_arbiter
  import gate_unit_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [CNT_W-1:0]       op_count,
  output logic                   busy
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  id_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_valid_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [CNT_W-1:0] cnt_q;

  logic [ID_W-1:0]  win;
  logic             found;
  logic [ID_W:0]    scan;
  logic [ID_W:0]    nxt;
  logic             hs;
  logic             acc;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] alu_y;

  // First valid requester at or after rr_q, modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, rr_q} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(N_REQ)) scan = scan - (ID_W+1)'(N_REQ);
      if (!found && req_valid[scan[ID_W-1:0]]) begin
        found = 1'b1;
        win   = scan[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == win) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  assign hs  = (state_q == ST_IDLE) && found;
  assign acc = (state_q == ST_RESP) && rsp_ready;

  always_comb begin
    req_ready = '0;
    if (rst_n && hs) req_ready[win] = 1'b1;
  end

  always_comb begin
    nxt = {1'b0, id_q} + (ID_W+1)'(1);
    if (nxt >= (ID_W+1)'(N_REQ)) nxt = '0;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: if (hs) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rr_d    = nxt[ID_W-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  gate_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op_i(op_q),
    .a_i (a_q),
    .b_i (b_q),
    .y_o (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (hs) begin
        op_q <= sel_op;
        a_q  <= sel_a;
        b_q  <= sel_b;
        id_q <= win;
      end
      if (state_q == ST_EXEC) begin
        rsp_data_q  <= alu_y;
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
      end
      if (acc) begin
        rsp_valid_q <= 1'b0;
        cnt_q       <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = cnt_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
